pulse_param_loader: RTL and testbench

Configuration front end for the pulse generator. Parses framed command bytes from the UART receiver into shadow copies of every pulse-timing parameter. It then transfers all shadows to the live parameter outputs atomically on a period boundary, so the pulse sequencer never sees a half-updated parameter set. Runs on the 50 MHz `clk` domain that already registers the sequencer's parameter inputs.

---
 rtl/pulse_param_loader.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_pulse_param_loader.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_param_loader.sv
// pulse_param_loader
// Parses 7-byte command frames (A5, addr, d3, d2, d1, d0, chk) from the UART
// receiver into shadow copies of the pulse-timing parameters. All shadows are
// then transferred to the live outputs in a single cycle on a period boundary.
// Ports:
//   clk           system clock
//   reset         asynchronous active-low reset
//   rx_data       received byte, qualified by rx_valid (one-cycle strobe)
//   period_start  one-cycle strobe at the pulse-counter wrap; commits occur here
//   per .. bl     live pulse parameters (registered)
//   pending       a commit command was accepted but is not yet applied
//   ack           one-cycle pulse per accepted frame
//   frame_err     one-cycle pulse per rejected or timed-out frame
//   committed     one-cycle pulse when the live parameters load
module pulse_param_loader #(
  parameter int TIMEOUT = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        period_start,
  output logic [31:0] per,
  output logic [15:0] p1wid,
  output logic [15:0] del,
  output logic [15:0] p2wid,
  output logic [7:0]  nut_w,
  output logic [15:0] nut_d,
  output logic [7:0]  cp,
  output logic [7:0]  p_bl,
  output logic [15:0] p_bl_off,
  output logic        bl,
  output logic        pending,
  output logic        ack,
  output logic        frame_err,
  output logic        committed
);

  // The counter only has to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  localparam logic [31:0] RST_PER      = 32'd65536;
  localparam logic [15:0] RST_P1WID    = 16'd30;
  localparam logic [15:0] RST_DEL      = 16'd200;
  localparam logic [15:0] RST_P2WID    = 16'd30;
  localparam logic [7:0]  RST_NUT_W    = 8'd50;
  localparam logic [15:0] RST_NUT_D    = 16'd300;
  localparam logic [7:0]  RST_CP       = 8'd3;
  localparam logic [7:0]  RST_P_BL     = 8'd50;
  localparam logic [15:0] RST_P_BL_OFF = 16'd100;
  localparam logic        RST_BL       = 1'b1;

  typedef enum logic [2:0] {
    S_HUNT = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_EXEC = 3'd4
  } state_t;

  // Parameter registers 0x00..0x09 and the commit command 0x0F.
  function automatic logic addr_mapped(input logic [7:0] a);
    addr_mapped = (a <= 8'h09) || (a == 8'h0F);
  endfunction

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    addr_q, addr_d;
  logic [31:0]   asm_q, asm_d;
  logic [7:0]    xor_q, xor_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          chk_err_s;
  logic          to_err_s;

  logic [31:0] sh_per_q, sh_per_d, lv_per_q, lv_per_d;
  logic [15:0] sh_p1wid_q, sh_p1wid_d, lv_p1wid_q, lv_p1wid_d;
  logic [15:0] sh_del_q, sh_del_d, lv_del_q, lv_del_d;
  logic [15:0] sh_p2wid_q, sh_p2wid_d, lv_p2wid_q, lv_p2wid_d;
  logic [7:0]  sh_nut_w_q, sh_nut_w_d, lv_nut_w_q, lv_nut_w_d;
  logic [15:0] sh_nut_d_q, sh_nut_d_d, lv_nut_d_q, lv_nut_d_d;
  logic [7:0]  sh_cp_q, sh_cp_d, lv_cp_q, lv_cp_d;
  logic [7:0]  sh_p_bl_q, sh_p_bl_d, lv_p_bl_q, lv_p_bl_d;
  logic [15:0] sh_p_bl_off_q, sh_p_bl_off_d, lv_p_bl_off_q, lv_p_bl_off_d;
  logic        sh_bl_q, sh_bl_d, lv_bl_q, lv_bl_d;
  logic        pending_q, pending_d;
  logic        ack_q, ack_d;
  logic        frame_err_q, frame_err_d;
  logic        committed_q, committed_d;

  // Frame parser state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: byte assembly, running checksum and inter-byte timeout.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    asm_d     = asm_q;
    xor_d     = xor_q;
    cnt_d     = '0;
    chk_err_s = 1'b0;
    to_err_s  = 1'b0;
    case (state_q)
      S_HUNT: begin
        // Anything other than a sync byte is dropped without a response.
        if (rx_valid && (rx_data == 8'hA5)) begin
          state_d = S_ADDR;
        end else begin
          state_d = S_HUNT;
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          addr_d  = rx_data;
          xor_d   = rx_data;
          idx_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          state_d = S_ADDR;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          asm_d = {asm_q[23:0], rx_data};
          xor_d = xor_q ^ rx_data;
          if (idx_q == 3'd3) begin
            state_d = S_CHK;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_CHK: begin
        if (rx_valid) begin
          if ((rx_data == xor_q) && addr_mapped(addr_q)) begin
            state_d = S_EXEC;
          end else begin
            chk_err_s = 1'b1;
            state_d   = S_HUNT;
          end
        end else begin
          state_d = S_CHK;
        end
      end
      S_EXEC: begin
        // Any byte arriving in this cycle is dropped.
        state_d = S_HUNT;
      end
      default: begin
        state_d = S_HUNT;
      end
    endcase

    // Idle cycles inside a frame are counted; any received byte restarts the count.
    if ((state_q == S_ADDR || state_q == S_DATA || state_q == S_CHK) && !rx_valid) begin
      if (cnt_q == TO_LAST) begin
        to_err_s = 1'b1;
        state_d  = S_HUNT;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Frame assembly registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q  <= 3'd0;
      addr_q <= 8'h00;
      asm_q  <= 32'h0000_0000;
      xor_q  <= 8'h00;
      cnt_q  <= '0;
    end else begin
      idx_q  <= idx_d;
      addr_q <= addr_d;
      asm_q  <= asm_d;
      xor_q  <= xor_d;
      cnt_q  <= cnt_d;
    end
  end

  // Output logic: shadow writes, atomic commit and status pulses.
  always_comb begin
    sh_per_d      = sh_per_q;
    sh_p1wid_d    = sh_p1wid_q;
    sh_del_d      = sh_del_q;
    sh_p2wid_d    = sh_p2wid_q;
    sh_nut_w_d    = sh_nut_w_q;
    sh_nut_d_d    = sh_nut_d_q;
    sh_cp_d       = sh_cp_q;
    sh_p_bl_d     = sh_p_bl_q;
    sh_p_bl_off_d = sh_p_bl_off_q;
    sh_bl_d       = sh_bl_q;
    lv_per_d      = lv_per_q;
    lv_p1wid_d    = lv_p1wid_q;
    lv_del_d      = lv_del_q;
    lv_p2wid_d    = lv_p2wid_q;
    lv_nut_w_d    = lv_nut_w_q;
    lv_nut_d_d    = lv_nut_d_q;
    lv_cp_d       = lv_cp_q;
    lv_p_bl_d     = lv_p_bl_q;
    lv_p_bl_off_d = lv_p_bl_off_q;
    lv_bl_d       = lv_bl_q;
    pending_d     = pending_q;
    ack_d         = 1'b0;
    committed_d   = 1'b0;
    frame_err_d   = chk_err_s | to_err_s;

    // Transfer reads the current shadows, so a write in this same cycle
    // lands in the shadow only and goes out with the next commit.
    if (period_start && pending_q) begin
      lv_per_d      = sh_per_q;
      lv_p1wid_d    = sh_p1wid_q;
      lv_del_d      = sh_del_q;
      lv_p2wid_d    = sh_p2wid_q;
      lv_nut_w_d    = sh_nut_w_q;
      lv_nut_d_d    = sh_nut_d_q;
      lv_cp_d       = sh_cp_q;
      lv_p_bl_d     = sh_p_bl_q;
      lv_p_bl_off_d = sh_p_bl_off_q;
      lv_bl_d       = sh_bl_q;
      pending_d     = 1'b0;
      committed_d   = 1'b1;
    end else begin
      committed_d = 1'b0;
    end

    // Executed after the transfer so a commit command arming in the same
    // cycle as period_start stays pending for the next boundary.
    if (state_q == S_EXEC) begin
      ack_d = 1'b1;
      case (addr_q)
        8'h00:   sh_per_d      = asm_q;
        8'h01:   sh_p1wid_d    = asm_q[15:0];
        8'h02:   sh_del_d      = asm_q[15:0];
        8'h03:   sh_p2wid_d    = asm_q[15:0];
        8'h04:   sh_nut_w_d    = asm_q[7:0];
        8'h05:   sh_nut_d_d    = asm_q[15:0];
        8'h06:   sh_cp_d       = asm_q[7:0];
        8'h07:   sh_p_bl_d     = asm_q[7:0];
        8'h08:   sh_p_bl_off_d = asm_q[15:0];
        8'h09:   sh_bl_d       = asm_q[0];
        8'h0F:   pending_d     = 1'b1;
        // Unmapped addresses are rejected before EXEC.
        default: ;
      endcase
    end else begin
      ack_d = 1'b0;
    end
  end

  // Shadow, live and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_per_q      <= RST_PER;
      sh_p1wid_q    <= RST_P1WID;
      sh_del_q      <= RST_DEL;
      sh_p2wid_q    <= RST_P2WID;
      sh_nut_w_q    <= RST_NUT_W;
      sh_nut_d_q    <= RST_NUT_D;
      sh_cp_q       <= RST_CP;
      sh_p_bl_q     <= RST_P_BL;
      sh_p_bl_off_q <= RST_P_BL_OFF;
      sh_bl_q       <= RST_BL;
      lv_per_q      <= RST_PER;
      lv_p1wid_q    <= RST_P1WID;
      lv_del_q      <= RST_DEL;
      lv_p2wid_q    <= RST_P2WID;
      lv_nut_w_q    <= RST_NUT_W;
      lv_nut_d_q    <= RST_NUT_D;
      lv_cp_q       <= RST_CP;
      lv_p_bl_q     <= RST_P_BL;
      lv_p_bl_off_q <= RST_P_BL_OFF;
      lv_bl_q       <= RST_BL;
      pending_q     <= 1'b0;
      ack_q         <= 1'b0;
      frame_err_q   <= 1'b0;
      committed_q   <= 1'b0;
    end else begin
      sh_per_q      <= sh_per_d;
      sh_p1wid_q    <= sh_p1wid_d;
      sh_del_q      <= sh_del_d;
      sh_p2wid_q    <= sh_p2wid_d;
      sh_nut_w_q    <= sh_nut_w_d;
      sh_nut_d_q    <= sh_nut_d_d;
      sh_cp_q       <= sh_cp_d;
      sh_p_bl_q     <= sh_p_bl_d;
      sh_p_bl_off_q <= sh_p_bl_off_d;
      sh_bl_q       <= sh_bl_d;
      lv_per_q      <= lv_per_d;
      lv_p1wid_q    <= lv_p1wid_d;
      lv_del_q      <= lv_del_d;
      lv_p2wid_q    <= lv_p2wid_d;
      lv_nut_w_q    <= lv_nut_w_d;
      lv_nut_d_q    <= lv_nut_d_d;
      lv_cp_q       <= lv_cp_d;
      lv_p_bl_q     <= lv_p_bl_d;
      lv_p_bl_off_q <= lv_p_bl_off_d;
      lv_bl_q       <= lv_bl_d;
      pending_q     <= pending_d;
      ack_q         <= ack_d;
      frame_err_q   <= frame_err_d;
      committed_q   <= committed_d;
    end
  end

  assign per       = lv_per_q;
  assign p1wid     = lv_p1wid_q;
  assign del       = lv_del_q;
  assign p2wid     = lv_p2wid_q;
  assign nut_w     = lv_nut_w_q;
  assign nut_d     = lv_nut_d_q;
  assign cp        = lv_cp_q;
  assign p_bl      = lv_p_bl_q;
  assign p_bl_off  = lv_p_bl_off_q;
  assign bl        = lv_bl_q;
  assign pending   = pending_q;
  assign ack       = ack_q;
  assign frame_err = frame_err_q;
  assign committed = committed_q;

endmodule

// File: tb/tb_pulse_param_loader.sv
// Testbench for pulse_param_loader: a frame-level model (byte queue, idle
// counter, shadow/live arrays) is stepped on every clock edge and compared
// with the DUT on every falling edge; directed literal checks pin the model.
module tb_pulse_param_loader;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        period_start = 1'b0;
  logic [31:0] per;
  logic [15:0] p1wid, del, p2wid, nut_d, p_bl_off;
  logic [7:0]  nut_w, cp, p_bl;
  logic        bl, pending, ack, frame_err, committed;

  always #5 clk = ~clk;

  pulse_param_loader #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .period_start(period_start), .per(per), .p1wid(p1wid), .del(del),
    .p2wid(p2wid), .nut_w(nut_w), .nut_d(nut_d), .cp(cp), .p_bl(p_bl),
    .p_bl_off(p_bl_off), .bl(bl), .pending(pending), .ack(ack),
    .frame_err(frame_err), .committed(committed)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam logic [31:0] RSTV [10] = '{32'd65536, 32'd30, 32'd200, 32'd30, 32'd50,
                                        32'd300, 32'd3, 32'd50, 32'd100, 32'd1};
  localparam int WID [10] = '{32, 16, 16, 16, 8, 16, 8, 8, 16, 1};

  logic [31:0] m_live [10];
  logic [31:0] m_sh [10];
  logic        m_pending, m_ack, m_err, m_comm;
  logic [7:0]  fq [$];
  int          idle_cnt;
  bit          exec_sched;
  logic [7:0]  exec_addr;
  logic [31:0] exec_data;

  function automatic logic [31:0] wmask(input int a);
    if (WID[a] == 32) return 32'hFFFF_FFFF;
    return (32'd1 << WID[a]) - 32'd1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 10; i++) begin
      m_live[i] = RSTV[i];
      m_sh[i]   = RSTV[i];
    end
    m_pending = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_comm = 1'b0;
    fq.delete();
    idle_cnt = 0;
    exec_sched = 1'b0;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_reset();
    end else begin
      m_ack = 1'b0; m_err = 1'b0; m_comm = 1'b0;
      if (period_start && m_pending) begin
        m_live = m_sh;
        m_pending = 1'b0;
        m_comm = 1'b1;
      end
      if (exec_sched) begin
        exec_sched = 1'b0;
        m_ack = 1'b1;
        if (exec_addr == 8'h0F) m_pending = 1'b1;
        else m_sh[exec_addr] = exec_data & wmask(int'(exec_addr));
      end else if (rx_valid) begin
        idle_cnt = 0;
        if (fq.size() == 0) begin
          if (rx_data == 8'hA5) fq.push_back(rx_data);
        end else begin
          fq.push_back(rx_data);
          if (fq.size() == 7) begin
            if (((fq[1] ^ fq[2] ^ fq[3] ^ fq[4] ^ fq[5]) == fq[6]) &&
                (fq[1] <= 8'h09 || fq[1] == 8'h0F)) begin
              exec_sched = 1'b1;
              exec_addr  = fq[1];
              exec_data  = {fq[2], fq[3], fq[4], fq[5]};
            end else begin
              m_err = 1'b1;
            end
            fq.delete();
          end
        end
      end else if (fq.size() != 0) begin
        idle_cnt++;
        if (idle_cnt == TO) begin
          m_err = 1'b1;
          fq.delete();
          idle_cnt = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 1'b0;
  int ack_cnt = 0, err_cnt = 0, comm_cnt = 0;

  always @(negedge clk) begin
    if (ack) ack_cnt++;
    if (frame_err) err_cnt++;
    if (committed) comm_cnt++;
    if (cmp_en) begin
      chk("per", per, m_live[0]);
      chk("p1wid", 32'(p1wid), m_live[1]);
      chk("del", 32'(del), m_live[2]);
      chk("p2wid", 32'(p2wid), m_live[3]);
      chk("nut_w", 32'(nut_w), m_live[4]);
      chk("nut_d", 32'(nut_d), m_live[5]);
      chk("cp", 32'(cp), m_live[6]);
      chk("p_bl", 32'(p_bl), m_live[7]);
      chk("p_bl_off", 32'(p_bl_off), m_live[8]);
      chk("bl", 32'(bl), m_live[9]);
      chk("pending", 32'(pending), 32'(m_pending));
      chk("ack", 32'(ack), 32'(m_ack));
      chk("frame_err", 32'(frame_err), 32'(m_err));
      chk("committed", 32'(committed), 32'(m_comm));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Sends a 7-byte frame MSB-first; gap < 0 means a random 0..4 idle gap.
  task automatic send7(input logic [55:0] f, input int gap);
    logic [55:0] s;
    s = f;
    for (int i = 0; i < 7; i++) begin
      send_byte(s[55:48]);
      s = s << 8;
      if (i != 6) idle((gap < 0) ? $urandom_range(0, 4) : gap);
    end
  endtask

  function automatic logic [55:0] mk_frame(input logic [7:0] a, input logic [31:0] d, input bit bad);
    logic [7:0] c;
    c = a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
    if (bad) c = c ^ 8'($urandom_range(1, 255));
    return {8'hA5, a, d, c};
  endfunction

  task automatic pulse_ps();
    period_start = 1'b1;
    tick();
    period_start = 1'b0;
  endtask

  task automatic check_reset_lits(input string tag);
    chk({tag, "_per"}, per, 32'd65536);
    chk({tag, "_p1wid"}, 32'(p1wid), 32'd30);
    chk({tag, "_del"}, 32'(del), 32'd200);
    chk({tag, "_p2wid"}, 32'(p2wid), 32'd30);
    chk({tag, "_nut_w"}, 32'(nut_w), 32'd50);
    chk({tag, "_nut_d"}, 32'(nut_d), 32'd300);
    chk({tag, "_cp"}, 32'(cp), 32'd3);
    chk({tag, "_p_bl"}, 32'(p_bl), 32'd50);
    chk({tag, "_p_bl_off"}, 32'(p_bl_off), 32'd100);
    chk({tag, "_bl"}, 32'(bl), 32'd1);
    chk({tag, "_pending"}, 32'(pending), 32'd0);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    chk({tag, "_committed"}, 32'(committed), 32'd0);
  endtask

  bit rand_on = 1'b0;

  initial begin
    int a0, e0, c0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    cmp_en = 1'b1;
    check_reset_lits("post_reset");

    // Write p1wid = 40, then commit.
    a0 = ack_cnt;
    send7(56'hA5_01_00_00_00_28_29, 1);
    idle(3);
    send7(56'hA5_0F_00_00_00_00_0F, 0);
    idle(3);
    chk("two_acks", 32'(ack_cnt - a0), 32'd2);
    chk("pending_armed", 32'(pending), 32'd1);
    chk("p1wid_not_yet", 32'(p1wid), 32'd30);
    c0 = comm_cnt;
    pulse_ps();
    chk("p1wid_committed", 32'(p1wid), 32'd40);
    chk("committed_pulse", 32'(committed), 32'd1);
    chk("pending_cleared", 32'(pending), 32'd0);
    tick();
    chk("committed_one_cycle", 32'(committed), 32'd0);
    chk("commit_count", 32'(comm_cnt - c0), 32'd1);

    // Bad checksum leaves del untouched.
    e0 = err_cnt;
    send7(56'hA5_02_00_00_01_00_00, 0);
    idle(3);
    chk("badchk_err", 32'(err_cnt - e0), 32'd1);
    send7(56'hA5_0F_00_00_00_00_0F, 0);
    idle(3);
    pulse_ps();
    chk("del_unchanged", 32'(del), 32'd200);

    // Junk bytes then an unmapped address.
    a0 = ack_cnt; e0 = err_cnt;
    send_byte(8'h11); idle(2); send_byte(8'h22); idle(2);
    chk("junk_silent", 32'(err_cnt - e0), 32'd0);
    send7(56'hA5_0A_00_00_00_01_0B, 1);
    idle(3);
    chk("unmapped_err", 32'(err_cnt - e0), 32'd1);
    chk("unmapped_noack", 32'(ack_cnt - a0), 32'd0);

    // Inter-byte timeout, then a good frame.
    e0 = err_cnt;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h12);
    idle(TO - 2);
    chk("no_early_timeout", 32'(err_cnt - e0), 32'd0);
    idle(7);
    chk("timeout_err", 32'(err_cnt - e0), 32'd1);
    a0 = ack_cnt;
    send7(56'hA5_03_00_00_00_3C_3F, 0);
    idle(3);
    chk("after_timeout_ack", 32'(ack_cnt - a0), 32'd1);
    send7(56'hA5_0F_00_00_00_00_0F, 0);
    idle(3);
    pulse_ps();
    chk("p2wid_60", 32'(p2wid), 32'd60);

    // Commit EXEC coincides with period_start: arms only.
    send7(56'hA5_04_00_00_00_07_03, 0);
    idle(3);
    send7(56'hA5_0F_00_00_00_00_0F, 0);
    pulse_ps();
    chk("coinc_pending", 32'(pending), 32'd1);
    chk("coinc_no_transfer", 32'(nut_w), 32'd50);
    chk("coinc_no_commit", 32'(committed), 32'd0);
    idle(2);
    pulse_ps();
    chk("coinc_later_transfer", 32'(nut_w), 32'd7);

    // Asynchronous reset while in DATA.
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    reset = 1'b0;
    #1;
    check_reset_lits("async_reset");
    #1 reset = 1'b1;
    idle(2);
    send7(56'hA5_0F_00_00_00_00_0F, 0);
    idle(3);
    pulse_ps();
    chk("shadow_reset_p1wid", 32'(p1wid), 32'd30);
    idle(2);

    // Randomized frames with random period_start pulses.
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          period_start = ($urandom_range(0, 7) == 0);
          tick();
        end
        period_start = 1'b0;
      end
    join_none
    for (int n = 0; n < 150; n++) begin
      logic [7:0] a;
      int sel;
      if ($urandom_range(0, 5) == 0) begin
        a = 8'($urandom_range(0, 255));
        if (a == 8'hA5) a = 8'h5A;
        send_byte(a);
        idle(2);
      end
      sel = $urandom_range(0, 13);
      if (sel <= 9) a = 8'(sel);
      else if (sel <= 11) a = 8'h0F;
      else if (sel == 12) a = 8'($urandom_range(10, 14));
      else a = 8'($urandom_range(16, 255));
      send7(mk_frame(a, $urandom, ($urandom_range(0, 5) == 0)), -1);
      idle($urandom_range(2, 5));
    end
    rand_on = 1'b0;
    idle(4);
    period_start = 1'b0;
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
